mxv_seq_nnbit_jkdim: RTL

//  Sequential scheduler for the fully-connected-layer matrix-vector product o = W*X.
//  (JxK)*(Kx1) -> (Jx1) is computed on ONE shared mac_comb instance, stepped over

---
 rtl/mxv_seq_nnbit_jkdim.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mxv_seq_nnbit_jkdim.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mxv_seq_nnbit_jkdim (with helper mac_comb)
//  Purpose  : Sequential matrix-vector product o = W*X for a fully-connected
//             layer. A single shared multiply-accumulate unit is stepped over
//             rows (outer) and columns (inner). Operands are latched on a
//             start handshake and the result is returned on valid/ready.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  mac_comb : purely combinational signed multiply-accumulate, s = s0 + a*b.
//  The product is formed at full precision and sign-extended to the
//  accumulator width before the add.
// ----------------------------------------------------------------------------
module mac_comb #(
    parameter int N = 8,
    parameter int L = 2*(N-1)+3
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [L-1:0] s0,
    output logic signed [L-1:0] s
);
    // Working width large enough for the exact product and the accumulator
    localparam int PW = (L > 2*N) ? L : 2*N;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod;

    assign a_ext = PW'(a);
    assign b_ext = PW'(b);
    assign prod  = a_ext * b_ext;
    assign s     = s0 + $signed(prod[L-1:0]);
endmodule

// ----------------------------------------------------------------------------
//  mxv_seq_nnbit_jkdim : scheduler around one mac_comb instance.
// ----------------------------------------------------------------------------
module mxv_seq_nnbit_jkdim #(
    parameter int N = 8,
    parameter int J = 3,
    parameter int K = 3,
    parameter int L = 2*(N-1)+K
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic [J*K*N-1:0] g_input,
    input  logic [K*N-1:0]   e_input,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [J*L-1:0]   o
);
    // Index widths sized so that J-1 and K-1 fit exactly
    localparam int RW = (J > 1) ? $clog2(J) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [N-1:0] w_mat [J][K];
    logic signed [N-1:0] x_vec [K];
    logic signed [L-1:0] acc;
    logic signed [L-1:0] acc_next;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic                last_col;
    logic                last_row;
    logic                accept;

    assign last_col = (col == CW'(K-1));
    assign last_row = (row == RW'(J-1));
    assign accept   = (state == IDLE) && start;
    assign busy     = (state != IDLE);
    assign o_valid  = (state == DONE);

    // Single shared MAC: current weight times current input, plus running sum
    mac_comb #(
        .N (N),
        .L (L)
    ) u_mac (
        .a  (w_mat[row][col]),
        .b  (x_vec[col]),
        .s0 (acc),
        .s  (acc_next)
    );

    // State register; reset aborts any computation immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start only in IDLE, o_ready only in DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last_row && last_col) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (o_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture on accept; row/column stepping and row write-back in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            row <= '0;
            col <= '0;
            o   <= '0;
            for (int r = 0; r < J; r++) begin
                for (int c = 0; c < K; c++) begin
                    w_mat[r][c] <= '0;
                end
            end
            for (int c = 0; c < K; c++) begin
                x_vec[c] <= '0;
            end
        end else if (accept) begin
            acc <= '0;
            row <= '0;
            col <= '0;
            o   <= '0;
            for (int r = 0; r < J; r++) begin
                for (int c = 0; c < K; c++) begin
                    w_mat[r][c] <= g_input[(r*K+c)*N +: N];
                end
            end
            for (int c = 0; c < K; c++) begin
                x_vec[c] <= e_input[c*N +: N];
            end
        end else if (state == RUN) begin
            if (last_col) begin
                o[row*L +: L] <= acc_next;
                acc           <= '0;
                col           <= '0;
                row           <= last_row ? '0 : row + RW'(1);
            end else begin
                acc <= acc_next;
                col <= col + CW'(1);
            end
        end
    end
endmodule
`default_nettype wire
